// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types, forwarding encodings and register-match helpers for the
// ID-stage hazard / forwarding controller.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W       = 5;
    localparam int MDU_LAT_DEF = 4;
    localparam int MDU_CNT_W   = 4;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EXE     = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;

    typedef enum logic [0:0] {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    typedef struct packed {
        logic             v;
        logic             wreg;
        logic             load;
        logic [REG_W-1:0] dst;
    } dst_entry_t;

    localparam dst_entry_t DST_EMPTY = '{v: 1'b0, wreg: 1'b0, load: 1'b0, dst: {REG_W{1'b0}}};

    // r0 is hardwired to zero, so it never matches a pending write
    function automatic logic reg_match(input dst_entry_t e, input logic [REG_W-1:0] r);
        return (r != {REG_W{1'b0}}) && e.v && e.wreg && (e.dst == r);
    endfunction

    // An EX-stage load has no data yet, so it falls through to the MEM checks
    function automatic logic [1:0] fwd_sel(input dst_entry_t ex, input dst_entry_t mem,
                                           input logic use_r, input logic [REG_W-1:0] r);
        logic [1:0] sel;
        sel = FWD_RF;
        if (!use_r) begin
            sel = FWD_RF;
        end else if (reg_match(ex, r) && !ex.load) begin
            sel = FWD_EXE;
        end else if (reg_match(mem, r) && !mem.load) begin
            sel = FWD_MEM_ALU;
        end else if (reg_match(mem, r)) begin
            sel = FWD_MEM_LD;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage decode fields in, pipeline enables and forwarding selects out.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wreg;
    logic [REG_W-1:0] id_dst;
    logic             id_load;
    logic             id_mdu;
    logic             id_hilo;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mdu_busy;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_dst,
               id_load, id_mdu, id_hilo,
        input  pc_en, ifid_en, idex_bubble, fwd_a, fwd_b, mdu_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_dst,
               id_load, id_mdu, id_hilo,
        output pc_en, ifid_en, idex_bubble, fwd_a, fwd_b, mdu_busy
    );

endinterface

// File: rtl/pipe_dst_track.sv
// Two-deep shadow of destination-register info for the EX and MEM stages;
// a bubble turns the entry entering EX into an invalid slot.
module pipe_dst_track
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  dst_entry_t id_entry,
    input  logic       bubble,
    output dst_entry_t ex,
    output dst_entry_t mem
);

    dst_entry_t ex_r;
    dst_entry_t mem_r;
    dst_entry_t ex_next_s;

    // Entry presented to the EX slot, squashed when ID is being held
    always_comb begin
        ex_next_s   = id_entry;
        ex_next_s.v = id_entry.v & ~bubble;
    end

    // Shift the shadow pipeline one stage per clock
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ex_r  <= DST_EMPTY;
            mem_r <= DST_EMPTY;
        end else begin
            ex_r  <= ex_next_s;
            mem_r <= ex_r;
        end
    end

    assign ex  = ex_r;
    assign mem = mem_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard detection, operand forwarding select and MDU busy tracking
// for the 5-stage pipeline; all outputs are combinational from ID and state.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF
) (
    input logic               Clk,
    input logic               Rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [MDU_CNT_W-1:0] MDU_RELOAD = MDU_CNT_W'(MDU_LAT - 1);

    dst_entry_t           id_entry_s;
    dst_entry_t           ex_s;
    dst_entry_t           mem_s;
    logic                 load_use_s;
    logic                 mdu_stall_s;
    logic                 stall_s;
    logic                 mdu_issue_s;
    mdu_state_t           mdu_state_r;
    logic [MDU_CNT_W-1:0] mdu_cnt_r;

    // Pack the ID-stage destination fields for the shadow pipeline
    always_comb begin
        id_entry_s = '{v: bus.id_valid, wreg: bus.id_wreg, load: bus.id_load, dst: bus.id_dst};
    end

    pipe_dst_track u_dst_track (
        .Clk      (Clk),
        .Rst      (Rst),
        .id_entry (id_entry_s),
        .bubble   (stall_s),
        .ex       (ex_s),
        .mem      (mem_s)
    );

    // Both hazard sources collapse into one stall so they never stack
    always_comb begin
        load_use_s  = bus.id_valid && ex_s.load &&
                      ((bus.id_use_rs && reg_match(ex_s, bus.id_rs)) ||
                       (bus.id_use_rt && reg_match(ex_s, bus.id_rt)));
        mdu_stall_s = bus.id_valid && (mdu_state_r == MDU_BUSY) && (bus.id_mdu || bus.id_hilo);
        stall_s     = load_use_s || mdu_stall_s;
        mdu_issue_s = bus.id_valid && bus.id_mdu && !stall_s;
    end

    // Pipeline enables, forwarding selects and busy flag; forced benign in reset
    always_comb begin
        bus.pc_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.idex_bubble = 1'b0;
        bus.fwd_a       = FWD_RF;
        bus.fwd_b       = FWD_RF;
        bus.mdu_busy    = 1'b0;
        if (Rst) begin
            bus.pc_en       = 1'b1;
            bus.ifid_en     = 1'b1;
            bus.idex_bubble = 1'b0;
            bus.fwd_a       = FWD_RF;
            bus.fwd_b       = FWD_RF;
            bus.mdu_busy    = 1'b0;
        end else begin
            bus.pc_en       = ~stall_s;
            bus.ifid_en     = ~stall_s;
            bus.idex_bubble = stall_s;
            bus.fwd_a       = fwd_sel(ex_s, mem_s, bus.id_use_rs, bus.id_rs);
            bus.fwd_b       = fwd_sel(ex_s, mem_s, bus.id_use_rt, bus.id_rt);
            bus.mdu_busy    = (mdu_state_r == MDU_BUSY);
        end
    end

    // MDU busy FSM: counts down MDU_LAT cycles after an unstalled issue
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mdu_state_r <= MDU_IDLE;
            mdu_cnt_r   <= {MDU_CNT_W{1'b0}};
        end else begin
            case (mdu_state_r)
                MDU_IDLE: begin
                    if (mdu_issue_s) begin
                        mdu_state_r <= MDU_BUSY;
                        mdu_cnt_r   <= MDU_RELOAD;
                    end else begin
                        mdu_state_r <= MDU_IDLE;
                        mdu_cnt_r   <= mdu_cnt_r;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_cnt_r == {MDU_CNT_W{1'b0}}) begin
                        mdu_state_r <= MDU_IDLE;
                        mdu_cnt_r   <= mdu_cnt_r;
                    end else begin
                        mdu_state_r <= MDU_BUSY;
                        mdu_cnt_r   <= mdu_cnt_r - 4'd1;
                    end
                end
                default: begin
                    mdu_state_r <= MDU_IDLE;
                    mdu_cnt_r   <= {MDU_CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; observed vector is
// {pc_en, ifid_en, idex_bubble, fwd_a, fwd_b, mdu_busy}.
module tb_pipe_hazard_ctrl;

    logic       clk_s;
    logic       rst_s;
    logic [7:0] obs_s;
    int         n_checks;
    int         n_errors;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MDU_LAT(4)) dut (
        .Clk (clk_s),
        .Rst (rst_s),
        .bus (bus)
    );

    assign obs_s = {bus.pc_en, bus.ifid_en, bus.idex_bubble, bus.fwd_a, bus.fwd_b, bus.mdu_busy};

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wreg,
                         input logic [4:0] dst, input logic ld, input logic mdu, input logic hilo);
        bus.id_valid  = v;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_use_rs = urs;
        bus.id_use_rt = urt;
        bus.id_wreg   = wreg;
        bus.id_dst    = dst;
        bus.id_load   = ld;
        bus.id_mdu    = mdu;
        bus.id_hilo   = hilo;
        #1;
    endtask

    task automatic idle_id();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic flush();
        idle_id();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_s = 1'b1;
        drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs_s !== 8'b11000000) begin
            n_errors++; $display("FAIL reset_outputs: got %b expected %b", obs_s, 8'b11000000);
        end
        tick();
        tick();
        rst_s = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);   // div
        n_checks++;
        if (obs_s !== 8'b11000000) begin
            n_errors++; $display("FAIL reset_div_issue: got %b expected %b", obs_s, 8'b11000000);
        end
        tick();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);   // add r3
        n_checks++;
        if (obs_s !== 8'b11000001) begin
            n_errors++; $display("FAIL reset_busy_before: got %b expected %b", obs_s, 8'b11000001);
        end
        tick();
        rst_s = 1'b1;                                                          // BUSY, cnt=2
        drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs_s !== 8'b11000000) begin
            n_errors++; $display("FAIL reset_mid_busy: got %b expected %b", obs_s, 8'b11000000);
        end
        tick();
        tick();
        rst_s = 1'b0;
        drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);   // mflo reading r3
        n_checks++;
        if (obs_s !== 8'b11000000) begin
            n_errors++; $display("FAIL reset_post: got %b expected %b", obs_s, 8'b11000000);
        end
        tick();
    endtask

    task automatic test_load_use();
        flush();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // lw r5
        n_checks++;
        if (obs_s !== 8'b11000000) begin
            n_errors++; $display("FAIL lu_lw: got %b expected %b", obs_s, 8'b11000000);
        end
        tick();
        drive(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);   // add r8,r5,r6
        n_checks++;
        if (obs_s !== 8'b00100000) begin
            n_errors++; $display("FAIL lu_stall: got %b expected %b", obs_s, 8'b00100000);
        end
        tick();
        n_checks++;
        if (obs_s !== 8'b11011000) begin
            n_errors++; $display("FAIL lu_release: got %b expected %b", obs_s, 8'b11011000);
        end
        tick();
    endtask

    task automatic test_fwd();
        flush();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);   // add r3
        tick();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);   // sub r4,r3,r3
        n_checks++;
        if (obs_s !== 8'b11001010) begin
            n_errors++; $display("FAIL fwd_ex: got %b expected %b", obs_s, 8'b11001010);
        end
        tick();
        flush();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);   // add r3
        tick();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);   // or r9
        n_checks++;
        if (obs_s !== 8'b11000000) begin
            n_errors++; $display("FAIL fwd_indep: got %b expected %b", obs_s, 8'b11000000);
        end
        tick();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_s !== 8'b11010100) begin
            n_errors++; $display("FAIL fwd_mem: got %b expected %b", obs_s, 8'b11010100);
        end
        tick();
        flush();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);   // add r3
        tick();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);   // add r3 again
        tick();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);   // rt not used
        n_checks++;
        if (obs_s !== 8'b11001000) begin
            n_errors++; $display("FAIL fwd_prio_use: got %b expected %b", obs_s, 8'b11001000);
        end
        tick();
    endtask

    task automatic test_reg0();
        flush();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);   // add r0
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_s !== 8'b11000000) begin
            n_errors++; $display("FAIL r0_alu: got %b expected %b", obs_s, 8'b11000000);
        end
        tick();
        flush();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);   // lw r0
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_s !== 8'b11000000) begin
            n_errors++; $display("FAIL r0_load: got %b expected %b", obs_s, 8'b11000000);
        end
        tick();
    endtask

    task automatic test_mdu();
        flush();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);   // div
        n_checks++;
        if (obs_s !== 8'b11000000) begin
            n_errors++; $display("FAIL mdu_issue: got %b expected %b", obs_s, 8'b11000000);
        end
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);   // mflo r8
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_s !== 8'b00100001) begin
                n_errors++; $display("FAIL mdu_stall_%0d: got %b expected %b", i, obs_s, 8'b00100001);
            end
            tick();
        end
        n_checks++;
        if (obs_s !== 8'b11000000) begin
            n_errors++; $display("FAIL mdu_release: got %b expected %b", obs_s, 8'b11000000);
        end
        tick();
    endtask

    task automatic test_combined();
        flush();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);   // div
        tick();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // lw r7
        n_checks++;
        if (obs_s !== 8'b11000001) begin
            n_errors++; $display("FAIL comb_lw: got %b expected %b", obs_s, 8'b11000001);
        end
        tick();
        drive(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);   // mult r7,r2
        n_checks++;
        if (obs_s !== 8'b00100001) begin
            n_errors++; $display("FAIL comb_stall0: got %b expected %b", obs_s, 8'b00100001);
        end
        tick();
        n_checks++;
        if (obs_s !== 8'b00111001) begin
            n_errors++; $display("FAIL comb_stall1: got %b expected %b", obs_s, 8'b00111001);
        end
        tick();
        n_checks++;
        if (obs_s !== 8'b00100001) begin
            n_errors++; $display("FAIL comb_stall2: got %b expected %b", obs_s, 8'b00100001);
        end
        tick();
        n_checks++;
        if (obs_s !== 8'b11000000) begin
            n_errors++; $display("FAIL comb_issue: got %b expected %b", obs_s, 8'b11000000);
        end
        tick();
        idle_id();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_s !== 8'b11000001) begin
                n_errors++; $display("FAIL comb_busy_%0d: got %b expected %b", i, obs_s, 8'b11000001);
            end
            tick();
        end
        n_checks++;
        if (obs_s !== 8'b11000000) begin
            n_errors++; $display("FAIL comb_idle: got %b expected %b", obs_s, 8'b11000000);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_s    = 1'b1;
        idle_id();
        test_reset();
        test_load_use();
        test_fwd();
        test_reg0();
        test_mdu();
        test_combined();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
